// File: rtl/clk_div_arbiter.sv
// clk_div_arbiter
//   Shares one clock_divider between NUM_REQ requesters. Requesters are granted
//   round-robin; the winner's half-period count is loaded into the divider, the
//   divider is released from reset and its rising output edges are counted. Once
//   the winner's hold length is reached the divider is put back into reset and
//   done pulses for that requester. Dropping req during RUN aborts without done.
//
// Ports
//   inclk          in   system clock, also clocks the divider
//   Reset          in   asynchronous active-low reset
//   req            in   per-requester request level
//   req_count      in   packed half-period counts, slice i = requester i
//   req_hold       in   packed hold lengths (divider rising edges), slice i = requester i
//   grant          out  one-hot owner of the divider
//   done           out  one-cycle pulse when the owner's hold completes
//   busy           out  high whenever the arbiter is not idle
//   div_clk_count  out  divider count input
//   div_reset_n    out  divider reset, active low
//   div_outclk     in   divider output, same clock domain as inclk

module clk_div_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned HOLD_W  = 16
) (
    input  logic                      inclk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CNT_W-1:0]  req_count,
    input  logic [NUM_REQ*HOLD_W-1:0] req_hold,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [CNT_W-1:0]          div_clk_count,
    output logic                      div_reset_n,
    input  logic                      div_outclk
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StLoad,
        StRun,
        StRelease
    } state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     winner_q, winner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [HOLD_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                prev_outclk_q;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    div_clk_count_q, div_clk_count_d;
    logic                div_reset_n_q, div_reset_n_d;

    logic                arb_found;
    logic [PtrW-1:0]     arb_idx;
    logic [HOLD_W-1:0]   arb_hold;
    logic [HOLD_W-1:0]   edge_inc;
    logic                rising;

    assign rising   = div_outclk & ~prev_outclk_q;
    assign edge_inc = edge_cnt_q + HOLD_W'(1);
    assign arb_hold = req_hold[arb_idx*HOLD_W +: HOLD_W];

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin : arb_search
        logic [PtrW:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
            if (cand >= (PtrW+1)'(NUM_REQ)) begin
                cand = cand - (PtrW+1)'(NUM_REQ);
            end
            if (!arb_found && req[cand[PtrW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PtrW-1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        winner_d        = winner_q;
        hold_d          = hold_q;
        edge_cnt_d      = edge_cnt_q;
        grant_d         = grant_q;
        done_d          = '0;
        div_clk_count_d = div_clk_count_q;
        div_reset_n_d   = div_reset_n_q;

        unique case (state_q)
            StIdle: begin
                div_reset_n_d = 1'b0;
                if (|req) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (arb_found) begin
                    state_d         = StLoad;
                    winner_d        = arb_idx;
                    // A zero hold would never terminate; run it as one edge.
                    hold_d          = (arb_hold == '0) ? HOLD_W'(1) : arb_hold;
                    grant_d         = NUM_REQ'(1) << arb_idx;
                    div_clk_count_d = req_count[arb_idx*CNT_W +: CNT_W];
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                state_d       = StRun;
                edge_cnt_d    = '0;
                div_reset_n_d = 1'b1;
            end
            StRun: begin
                if (rising) begin
                    edge_cnt_d = edge_inc;
                end
                // Completion takes precedence over a same-cycle drop of req.
                if (rising && (edge_inc == hold_q)) begin
                    state_d       = StRelease;
                    grant_d       = '0;
                    div_reset_n_d = 1'b0;
                    done_d        = NUM_REQ'(1) << winner_q;
                end else if (!req[winner_q]) begin
                    state_d       = StRelease;
                    grant_d       = '0;
                    div_reset_n_d = 1'b0;
                end
            end
            StRelease: begin
                state_d  = StIdle;
                rr_ptr_d = (winner_q == PtrW'(NUM_REQ - 1)) ? '0 : winner_q + PtrW'(1);
            end
            default: begin
                state_d       = StIdle;
                grant_d       = '0;
                div_reset_n_d = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            winner_q        <= '0;
            hold_q          <= '0;
            edge_cnt_q      <= '0;
            prev_outclk_q   <= 1'b0;
            grant_q         <= '0;
            done_q          <= '0;
            busy_q          <= 1'b0;
            div_clk_count_q <= '0;
            div_reset_n_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            winner_q        <= winner_d;
            hold_q          <= hold_d;
            edge_cnt_q      <= edge_cnt_d;
            prev_outclk_q   <= div_outclk;
            grant_q         <= grant_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            div_clk_count_q <= div_clk_count_d;
            div_reset_n_q   <= div_reset_n_d;
        end
    end

    assign grant         = grant_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign div_clk_count = div_clk_count_q;
    assign div_reset_n   = div_reset_n_q;

endmodule

// File: tb/tb_clk_div_arbiter.sv
// tb_clk_div_arbiter
//   Drives clk_div_arbiter with directed and randomized requests, with a
//   behavioural divider on div_clk_count/div_reset_n/div_outclk. Expected
//   winners come from a round-robin model; expected edge counts and release
//   times come from the divider period formula.

module tb_clk_div_arbiter;

    localparam int NR = 4;
    localparam int CW = 32;
    localparam int HW = 16;

    logic              inclk = 1'b0;
    logic              Reset = 1'b0;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  req_count;
    logic [NR*HW-1:0]  req_hold;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [CW-1:0]     div_clk_count;
    logic              div_reset_n;
    logic              div_outclk;

    int checks = 0;
    int errors = 0;
    int rr     = 0;
    int cnt_a[NR];
    int hold_a[NR];

    clk_div_arbiter #(
        .NUM_REQ (NR),
        .CNT_W   (CW),
        .HOLD_W  (HW)
    ) dut (
        .inclk         (inclk),
        .Reset         (Reset),
        .req           (req),
        .req_count     (req_count),
        .req_hold      (req_hold),
        .grant         (grant),
        .done          (done),
        .busy          (busy),
        .div_clk_count (div_clk_count),
        .div_reset_n   (div_reset_n),
        .div_outclk    (div_outclk)
    );

    always #5 inclk = ~inclk;

    // Divider: output toggles every count+1 cycles, first toggle on the first
    // clock after its reset is released.
    logic [CW-1:0] dcnt;
    always @(posedge inclk) begin
        if (!div_reset_n) begin
            dcnt       <= '0;
            div_outclk <= 1'b0;
        end else if (dcnt == '0) begin
            div_outclk <= ~div_outclk;
            dcnt       <= div_clk_count;
        end else begin
            dcnt <= dcnt - 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] m, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (m[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    task automatic set_slot(input int i, input int c, input int h);
        req_count[i*CW +: CW] = CW'(c);
        req_hold[i*HW +: HW]  = HW'(h);
        cnt_a[i]  = c;
        hold_a[i] = h;
    endtask

    // Called at a negedge with the DUT idle and req already driven. Returns at
    // the negedge following the done pulse.
    task automatic serve(input int exp, input int c, input int h, input bit drop);
        int  n, heff, edges, run, bound;
        logic prev;
        bit  stable;
        n = 0;
        while (grant == '0 && n < 10) begin
            @(negedge inclk);
            n++;
        end
        check_eq("grant_latency", n, 2);
        check_eq("grant_owner", grant, NR'(1) << exp);
        check_eq("div_clk_count", div_clk_count, c);
        check_eq("div_reset_n_load", div_reset_n, 0);
        heff   = (h == 0) ? 1 : h;
        bound  = 2 * (c + 1) * heff + 10;
        edges  = 0;
        run    = 0;
        stable = 1'b1;
        prev   = div_outclk;
        do begin
            @(negedge inclk);
            run++;
            if (div_outclk && !prev) edges++;
            prev = div_outclk;
            if (run == 1) check_eq("div_reset_n_run", div_reset_n, 1);
            if (grant != '0 && done == '0 && grant != (NR'(1) << exp)) stable = 1'b0;
        end while (grant != '0 && done == '0 && run < bound);
        check_eq("grant_stable", stable, 1);
        check_eq("edges", edges, heff);
        check_eq("done", done, NR'(1) << exp);
        check_eq("release_time", run, 3 + (heff - 1) * 2 * (c + 1));
        check_eq("grant_released", grant, 0);
        check_eq("div_reset_n_rel", div_reset_n, 0);
        rr = (exp + 1) % NR;
        if (drop) req[exp] = 1'b0;
        @(negedge inclk);
        check_eq("done_pulse", done, 0);
    endtask

    initial begin
        logic [NR-1:0] mask;
        int   n, edges, exp, c, h;
        logic prev;
        bit   drop;

        req       = '0;
        req_count = '0;
        req_hold  = '0;
        repeat (3) @(negedge inclk);
        Reset = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 50; i++) begin
            @(negedge inclk);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_grant", grant, 0);
            check_eq("idle_div_reset_n", div_reset_n, 0);
        end

        // All four requesting, hold 1, kept high: 0,1,2,3,0.
        for (int i = 0; i < NR; i++) set_slot(i, $urandom_range(0, 2), 1);
        req = '1;
        for (int g = 0; g < 5; g++) serve(g % NR, cnt_a[g % NR], 1, 1'b0);
        req = '0;

        // Single request, count 3, hold 2.
        set_slot(0, 3, 2);
        req = 4'b0001;
        serve(0, 3, 2, 1'b1);

        // Zero hold behaves as one.
        set_slot(2, $urandom_range(0, 3), 0);
        req = 4'b0100;
        serve(2, cnt_a[2], 0, 1'b1);

        // Abort after 10 edges of a 100-edge hold.
        set_slot(1, 1, 100);
        req = 4'b0010;
        n = 0;
        while (grant == '0 && n < 10) begin
            @(negedge inclk);
            n++;
        end
        check_eq("abort_grant", grant, 4'b0010);
        edges = 0;
        n     = 0;
        prev  = div_outclk;
        while (edges < 10 && n < 200) begin
            @(negedge inclk);
            n++;
            if (div_outclk && !prev) edges++;
            prev = div_outclk;
        end
        check_eq("abort_edges", edges, 10);
        check_eq("abort_still_granted", grant, 4'b0010);
        req = '0;
        @(negedge inclk);
        check_eq("abort_grant_rel", grant, 0);
        check_eq("abort_no_done", done, 0);
        check_eq("abort_div_reset_n", div_reset_n, 0);
        check_eq("abort_busy", busy, 1);
        @(negedge inclk);
        check_eq("abort_no_done2", done, 0);
        check_eq("abort_idle", busy, 0);
        rr = 2;
        set_slot(0, 0, 1);
        set_slot(2, 1, 1);
        req = 4'b0101;
        serve(pick(4'b0101, rr), 1, 1, 1'b1);
        serve(pick(req, rr), 0, 1, 1'b1);

        // Randomized contention against the round-robin model.
        mask = '0;
        for (int r = 0; r < 24; r++) begin
            if (mask == '0) mask = NR'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, NR - 1)] = 1'b1;
            for (int i = 0; i < NR; i++) set_slot(i, $urandom_range(0, 3), $urandom_range(0, 3));
            req  = mask;
            exp  = pick(mask, rr);
            drop = 1'($urandom_range(0, 1));
            serve(exp, cnt_a[exp], hold_a[exp], drop);
            if (drop) mask[exp] = 1'b0;
        end
        req = '0;
        @(negedge inclk);

        // Reset in the middle of a run.
        set_slot(2, 1, 5);
        req = 4'b0100;
        n = 0;
        while (grant == '0 && n < 10) begin
            @(negedge inclk);
            n++;
        end
        check_eq("rst_grant", grant, 4'b0100);
        edges = 0;
        n     = 0;
        prev  = div_outclk;
        while (edges < 2 && n < 50) begin
            @(negedge inclk);
            n++;
            if (div_outclk && !prev) edges++;
            prev = div_outclk;
        end
        check_eq("rst_edges", edges, 2);
        Reset = 1'b0;
        #1;
        check_eq("rst_grant_clear", grant, 0);
        check_eq("rst_div_reset_n", div_reset_n, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        req = '0;
        repeat (3) @(negedge inclk);
        Reset = 1'b1;
        rr = 0;
        @(negedge inclk);
        set_slot(0, 1, 2);
        set_slot(3, 0, 3);
        req = 4'b1001;
        serve(pick(4'b1001, rr), 1, 2, 1'b1);
        serve(pick(req, rr), 0, 3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
